platform_collision_scan: RTL and testbench



---
 rtl/platform_collision_scan.sv | 210 +++++++++++++++++++++
 tb/tb_platform_collision_scan.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/platform_collision_scan.sv
// Per-frame collision sequencer: walks the platform table one entry per cycle
// against Mario's box and publishes registered blocking flags and a landing height.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for frame_start; result outputs hold last values
// SCAN    | evaluating entry idx, OR-ing hits into the accumulators
// PUBLISH | accumulators copied to outputs on exit, done pulses
module platform_collision_scan #(
  parameter int N_OBJ = 8,
  parameter int SPR   = 16,
  parameter int TOL   = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_start,
  input  logic [9:0]               mario_x,
  input  logic [9:0]               mario_y,
  input  logic                     cfg_we,
  input  logic [$clog2(N_OBJ)-1:0] cfg_idx,
  input  logic                     cfg_valid,
  input  logic [9:0]               cfg_x,
  input  logic [9:0]               cfg_y,
  input  logic [9:0]               cfg_w,
  input  logic [9:0]               cfg_h,
  output logic                     busy,
  output logic                     done,
  output logic                     hit_up,
  output logic                     hit_down,
  output logic                     hit_left,
  output logic                     hit_right,
  output logic [9:0]               land_y
);

  localparam int IW = $clog2(N_OBJ);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PUBLISH} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [9:0]    mx_q, mx_d, my_q, my_d;
  logic          acc_up_q, acc_up_d, acc_dn_q, acc_dn_d;
  logic          acc_lf_q, acc_lf_d, acc_rt_q, acc_rt_d;
  logic [9:0]    acc_land_q, acc_land_d;
  logic          done_q, done_d;
  logic          up_q, up_d, dn_q, dn_d, lf_q, lf_d, rt_q, rt_d;
  logic [9:0]    land_q, land_d;

  logic [N_OBJ-1:0] valid_q, valid_d;
  logic [9:0]       ox_q [N_OBJ];
  logic [9:0]       oy_q [N_OBJ];
  logic [9:0]       ow_q [N_OBJ];
  logic [9:0]       oh_q [N_OBJ];
  logic [9:0]       ox_d [N_OBJ];
  logic [9:0]       oy_d [N_OBJ];
  logic [9:0]       ow_d [N_OBJ];
  logic [9:0]       oh_d [N_OBJ];

  // Entry under evaluation; all edge sums are 11 bits so nothing wraps.
  logic        e_en;
  logic [10:0] mx11, my11, mx_end, my_end;
  logic [10:0] ox11, oy11, ox_end, oy_end, up_lo, lf_lo;
  logic        hov, vov, e_up, e_dn, e_lf, e_rt;

  always_comb begin
    e_en   = valid_q[idx_q] && (ow_q[idx_q] != 10'd0) && (oh_q[idx_q] != 10'd0);
    mx11   = {1'b0, mx_q};
    my11   = {1'b0, my_q};
    mx_end = mx11 + 11'(SPR);
    my_end = my11 + 11'(SPR);
    ox11   = {1'b0, ox_q[idx_q]};
    oy11   = {1'b0, oy_q[idx_q]};
    ox_end = ox11 + {1'b0, ow_q[idx_q]};
    oy_end = oy11 + {1'b0, oh_q[idx_q]};
    up_lo  = (oy_end < 11'(TOL)) ? 11'd0 : oy_end - 11'(TOL);
    lf_lo  = (ox_end < 11'(TOL)) ? 11'd0 : ox_end - 11'(TOL);
    hov    = (mx_end > ox11) && (mx11 < ox_end);
    vov    = (my_end > oy11) && (my11 < oy_end);
    e_dn   = e_en && hov && (my_end >= oy11) && (my_end <= oy11 + 11'(TOL));
    e_up   = e_en && hov && (my11 >= up_lo) && (my11 <= oy_end);
    e_rt   = e_en && vov && (mx_end >= ox11) && (mx_end <= ox11 + 11'(TOL));
    e_lf   = e_en && vov && (mx11 >= lf_lo) && (mx11 <= ox_end);
  end

  // Table writes are independent of the FSM; a same-cycle write is seen next edge.
  always_comb begin
    valid_d = valid_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    ow_d    = ow_q;
    oh_d    = oh_q;
    if (cfg_we && (int'(cfg_idx) < N_OBJ)) begin
      valid_d[cfg_idx] = cfg_valid;
      ox_d[cfg_idx]    = cfg_x;
      oy_d[cfg_idx]    = cfg_y;
      ow_d[cfg_idx]    = cfg_w;
      oh_d[cfg_idx]    = cfg_h;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mx_d       = mx_q;
    my_d       = my_q;
    acc_up_d   = acc_up_q;
    acc_dn_d   = acc_dn_q;
    acc_lf_d   = acc_lf_q;
    acc_rt_d   = acc_rt_q;
    acc_land_d = acc_land_q;
    done_d     = 1'b0;
    up_d       = up_q;
    dn_d       = dn_q;
    lf_d       = lf_q;
    rt_d       = rt_q;
    land_d     = land_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          mx_d       = mario_x;
          my_d       = mario_y;
          acc_up_d   = 1'b0;
          acc_dn_d   = 1'b0;
          acc_lf_d   = 1'b0;
          acc_rt_d   = 1'b0;
          acc_land_d = 10'h3FF;
          idx_d      = '0;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        acc_up_d = acc_up_q | e_up;
        acc_dn_d = acc_dn_q | e_dn;
        acc_lf_d = acc_lf_q | e_lf;
        acc_rt_d = acc_rt_q | e_rt;
        if (e_dn && (oy_q[idx_q] < acc_land_q)) acc_land_d = oy_q[idx_q];
        if (idx_q == IW'(N_OBJ - 1)) begin
          state_d = S_PUBLISH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_PUBLISH: begin
        up_d    = acc_up_q;
        dn_d    = acc_dn_q;
        lf_d    = acc_lf_q;
        rt_d    = acc_rt_q;
        land_d  = acc_dn_q ? acc_land_q : 10'd0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      mx_q       <= '0;
      my_q       <= '0;
      acc_up_q   <= 1'b0;
      acc_dn_q   <= 1'b0;
      acc_lf_q   <= 1'b0;
      acc_rt_q   <= 1'b0;
      acc_land_q <= '0;
      done_q     <= 1'b0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      lf_q       <= 1'b0;
      rt_q       <= 1'b0;
      land_q     <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mx_q       <= mx_d;
      my_q       <= my_d;
      acc_up_q   <= acc_up_d;
      acc_dn_q   <= acc_dn_d;
      acc_lf_q   <= acc_lf_d;
      acc_rt_q   <= acc_rt_d;
      acc_land_q <= acc_land_d;
      done_q     <= done_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      lf_q       <= lf_d;
      rt_q       <= rt_d;
      land_q     <= land_d;
      valid_q    <= valid_d;
    end
  end

  // Geometry fields need no reset: an entry is inert until its valid bit is written.
  always_ff @(posedge Clk) begin
    ox_q <= ox_d;
    oy_q <= oy_d;
    ow_q <= ow_d;
    oh_q <= oh_d;
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hit_up    = up_q;
  assign hit_down  = dn_q;
  assign hit_left  = lf_q;
  assign hit_right = rt_q;
  assign land_y    = land_q;

endmodule

// File: tb/tb_platform_collision_scan.sv
// Scoreboard bench for platform_collision_scan: stimulus queues expected results,
// a monitor pops and compares on every done pulse.
module tb_platform_collision_scan;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_start;
  logic [9:0] mario_x, mario_y;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic       cfg_valid;
  logic [9:0] cfg_x, cfg_y, cfg_w, cfg_h;
  logic       busy, done, hit_up, hit_down, hit_left, hit_right;
  logic [9:0] land_y;

  platform_collision_scan #(.N_OBJ(8), .SPR(16), .TOL(4)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .mario_x(mario_x), .mario_y(mario_y),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .busy(busy), .done(done),
    .hit_up(hit_up), .hit_down(hit_down), .hit_left(hit_left), .hit_right(hit_right),
    .land_y(land_y)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       up, dn, lf, rt;
    logic [9:0] land;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (done) begin
      done_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done seen at cycle %0d with nothing expected", cyc);
      end else begin
        mon_e = q.pop_front();
        if ({hit_up, hit_down, hit_left, hit_right} !== {mon_e.up, mon_e.dn, mon_e.lf, mon_e.rt}
            || land_y !== mon_e.land) begin
          errors++;
          $display("FAIL result: got u/d/l/r=%b%b%b%b land=%0d, expected %b%b%b%b land=%0d",
                   hit_up, hit_down, hit_left, hit_right, land_y,
                   mon_e.up, mon_e.dn, mon_e.lf, mon_e.rt, mon_e.land);
        end
        checks++;
        if (cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL latency: done at cycle %0d, expected cycle %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic cfg_write(input int idx, input logic v, input int x, input int y,
                           input int w, input int h);
    @(negedge Clk);
    cfg_we = 1'b1; cfg_idx = idx[2:0]; cfg_valid = v;
    cfg_x = x[9:0]; cfg_y = y[9:0]; cfg_w = w[9:0]; cfg_h = h[9:0];
    @(negedge Clk);
    cfg_we = 1'b0;
  endtask

  // Pulses frame_start; returns at the negedge just after acceptance edge E0.
  task automatic run_frame(input int mx, input int my, input logic push,
                           input logic up, input logic dn, input logic lf, input logic rt,
                           input int land);
    exp_t e;
    @(negedge Clk);
    mario_x = mx[9:0]; mario_y = my[9:0]; frame_start = 1'b1;
    if (push) begin
      e.up = up; e.dn = dn; e.lf = lf; e.rt = rt; e.land = land[9:0];
      e.cyc = cyc + 10;
      q.push_back(e);
    end
    @(negedge Clk);
    frame_start = 1'b0;
    mario_x = 10'h155; mario_y = 10'h2AA;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_flags"}, int'({hit_up, hit_down, hit_left, hit_right}), 0);
    chk({name, "_land"}, int'(land_y), 0);
  endtask

  initial begin
    int dc;
    Reset = 1'b1; frame_start = 1'b0; mario_x = '0; mario_y = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0;
    cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0;
    repeat (3) @(negedge Clk);
    chk_outputs_zero("reset");
    Reset = 1'b0;

    // Landing on a platform, then bumping its underside
    cfg_write(0, 1'b1, 96, 368, 64, 16);
    run_frame(100, 352, 1'b1, 0, 1, 0, 0, 368); wait_drain("t1");
    run_frame(100, 382, 1'b1, 1, 0, 0, 0, 0);   wait_drain("t2");

    // Side contacts
    cfg_write(0, 1'b0, 96, 368, 64, 16);
    cfg_write(1, 1'b1, 200, 300, 32, 64);
    run_frame(186, 320, 1'b1, 0, 0, 0, 1, 0);   wait_drain("t3r");
    run_frame(230, 320, 1'b1, 0, 0, 1, 0, 0);   wait_drain("t3l");

    // Two down hits: highest (smallest y) wins
    cfg_write(2, 1'b1, 0, 400, 640, 16);
    cfg_write(3, 1'b1, 90, 398, 40, 8);
    run_frame(100, 384, 1'b1, 0, 1, 0, 0, 398); wait_drain("t4");

    // Screen-edge arithmetic
    cfg_write(1, 1'b0, 0, 0, 0, 0);
    cfg_write(2, 1'b0, 0, 0, 0, 0);
    cfg_write(3, 1'b0, 0, 0, 0, 0);
    cfg_write(0, 1'b1, 1000, 1000, 23, 23);
    run_frame(1000, 1000, 1'b1, 0, 0, 0, 0, 0); wait_drain("t5a");
    cfg_write(0, 1'b1, 1000, 1020, 20, 3);
    run_frame(1000, 1005, 1'b1, 0, 1, 0, 0, 1020); wait_drain("t5b");

    // Zero-width entry would otherwise report a left hit
    cfg_write(0, 1'b1, 100, 300, 0, 64);
    run_frame(98, 320, 1'b1, 0, 0, 0, 0, 0);    wait_drain("t5c");

    // Invalidate entry 3 in the very cycle it is scanned
    cfg_write(0, 1'b0, 0, 0, 0, 0);
    cfg_write(3, 1'b1, 96, 368, 64, 16);
    run_frame(100, 352, 1'b1, 0, 1, 0, 0, 368);
    repeat (3) @(negedge Clk);
    cfg_we = 1'b1; cfg_idx = 3'd3; cfg_valid = 1'b0;
    @(negedge Clk);
    cfg_we = 1'b0;
    wait_drain("t5d");
    run_frame(100, 352, 1'b1, 0, 0, 0, 0, 0);   wait_drain("t5e");

    // Extra frame_start mid-scan and during PUBLISH are ignored
    cfg_write(3, 1'b1, 96, 368, 64, 16);
    dc = done_cnt;
    run_frame(100, 352, 1'b1, 0, 1, 0, 0, 368);
    repeat (2) @(negedge Clk);
    frame_start = 1'b1; mario_x = 10'd186; mario_y = 10'd320;
    @(negedge Clk);
    frame_start = 1'b0;
    repeat (5) @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    repeat (20) @(negedge Clk);
    chk("t6a_done_count", done_cnt - dc, 1);
    chk("t6a_queue", q.size(), 0);

    // Reset at scan cycle 4 aborts the frame and clears outputs and table
    dc = done_cnt;
    run_frame(100, 352, 1'b0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk_outputs_zero("t6b");
    repeat (15) @(negedge Clk);
    chk("t6b_no_done", done_cnt - dc, 0);
    run_frame(100, 352, 1'b1, 0, 0, 0, 0, 0);   wait_drain("t6b_table");

    // Back-to-back frames
    cfg_write(3, 1'b1, 96, 368, 64, 16);
    run_frame(100, 352, 1'b1, 0, 1, 0, 0, 368); wait_drain("t6c1");
    run_frame(100, 382, 1'b1, 1, 0, 0, 0, 0);   wait_drain("t6c2");

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

endmodule
